pmem_arbiter: RTL and testbench
===============================

PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning the number of cycles from request acceptance to the memory access cycle; legal range is 1..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have IFU request ports: ifu_req_valid in 1, ifu_req_ready out 1, ifu_addr in 32.
REQ-005 SHALL have IFU response ports: ifu_resp_valid out 1, ifu_resp_ready in 1, ifu_resp_data out 32.
REQ-006 SHALL have LSU request ports: lsu_req_valid in 1, lsu_req_ready out 1, lsu_addr in 32, lsu_wen in 1, lsu_wdata in 32, lsu_wmask in 8.
REQ-007 SHALL have LSU response ports: lsu_resp_valid out 1, lsu_resp_ready in 1, lsu_resp_data out 32.
REQ-008 SHALL have memory-side ports: mem_valid out 1, mem_raddr out 32, mem_rdata in 32 (combinational in the same cycle as mem_valid), mem_wen out 1, mem_waddr out 32, mem_wdata out 32, mem_wmask out 8.

Function
REQ-009 SHALL implement the FSM states IDLE, WAIT and RESP; exactly one transaction is in flight at a time.
REQ-010 SHALL drive req_ready only in IDLE, and only to the granted requester; the other requester's ready SHALL be 0.
REQ-011 SHALL arbitrate round-robin in IDLE: a lone valid requester wins; on a tie, the requester not granted last wins; the last-grant pointer resets to IFU, so the first tie goes to LSU.
REQ-012 SHALL treat a request as accepted when valid&&ready; on acceptance it SHALL latch the owner, addr, wen, wdata and wmask, load cnt=LATENCY-1, update the last-grant pointer, and move to WAIT.
REQ-013 SHALL treat IFU transactions as reads: the latched wen=0 and wmask=0.
REQ-014 SHALL decrement cnt by 1 per cycle in WAIT; mem_valid SHALL be 1 only in the WAIT cycle where cnt==0, exactly once per transaction.
REQ-015 SHALL, during the mem_valid cycle, drive mem_raddr=mem_waddr=latched addr, mem_wen=latched wen, mem_wdata=latched wdata and mem_wmask=latched wmask.
REQ-016 SHALL drive all mem_* outputs to 0 whenever mem_valid=0.
REQ-017 SHALL, in the mem_valid cycle, capture mem_rdata into the response register (0 if the latched wen=1) and move to RESP.
REQ-018 SHALL, in RESP, hold the owner's resp_valid=1 and its resp_data stable until the owner's resp_ready=1, then return to IDLE on the next edge; the non-owner resp_valid SHALL be 0.
REQ-019 SHALL give latency, with ready/valid returning at 1: acceptance at cycle T, mem_valid at T+LATENCY, resp_valid first high at T+LATENCY+1, and the next acceptance no earlier than one cycle after the resp handshake.
REQ-020 SHALL ignore new requests and any changes to requester inputs while in WAIT or RESP; ready SHALL be 0 in those states.
REQ-021 SHALL drive resp_data to 0 whenever the corresponding resp_valid=0.

Reset
REQ-022 SHALL, while rst_n=0 at a clock edge, set state=IDLE, cnt=0, last-grant=IFU and the response register to 0.
REQ-023 SHALL force all outputs (ready, resp_valid, resp_data, mem_*) to 0 while rst_n=0.
REQ-024 SHALL, when reset is asserted mid-transaction, discard the transaction: no mem_valid and no resp_valid for it.

Verification
REQ-025 Bench SHALL cover: LATENCY=1, IFU read addr 0x80000000 with mem_rdata 0x00000413 accepted at T -> mem_valid at T+1 with mem_raddr 0x80000000; ifu_resp_valid=1 and data 0x00000413 at T+2.
REQ-026 Bench SHALL cover: IFU and LSU both valid out of reset -> LSU granted first, IFU second; both held valid again -> grants alternate LSU, IFU, LSU.
REQ-027 Bench SHALL cover: LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F -> exactly one mem_valid cycle with mem_wen=1 and those values; lsu_resp_valid with data 0.
REQ-028 Bench SHALL cover: LATENCY=3, resp_ready held 0 for 4 cycles -> mem_valid at T+3, resp_valid held 4+ cycles with data stable, IFU request ignored until return to IDLE.
REQ-029 Bench SHALL cover: rst_n pulled low at T+1 of a LATENCY=3 transaction -> no mem_valid, all outputs 0, and the next tie grants LSU.

Source files
------------

// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_arbiter
//  Description : Round-robin IFU/LSU arbiter onto a single memory port,
//                one transaction in flight, fixed access latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module pmem_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_resp_data,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_resp_data,

    output logic        mem_valid,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [3:0]  r_cnt;
    logic        r_last_lsu;
    logic        r_owner_lsu;
    logic        r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [7:0]  r_wmask;
    logic [31:0] r_resp_data;

    logic        w_idle;
    logic        w_grant_lsu;
    logic        w_grant_ifu;
    logic        w_accept;
    logic        w_mem_fire;
    logic        w_in_resp;
    logic        w_resp_done;

    // Grant implies valid, so ready == grant and acceptance == any grant.
    always_comb begin
        w_idle      = rst_n && (r_state == c_ST_IDLE);
        w_grant_lsu = w_idle && lsu_req_valid && (!ifu_req_valid || !r_last_lsu);
        w_grant_ifu = w_idle && ifu_req_valid && !w_grant_lsu;
        w_accept    = w_grant_lsu || w_grant_ifu;
        w_mem_fire  = rst_n && (r_state == c_ST_WAIT) && (r_cnt == 4'd0);
        w_in_resp   = rst_n && (r_state == c_ST_RESP);
        w_resp_done = w_in_resp && (r_owner_lsu ? lsu_resp_ready : ifu_resp_ready);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept)    w_state_next = c_ST_WAIT;
            c_ST_WAIT: if (w_mem_fire)  w_state_next = c_ST_RESP;
            c_ST_RESP: if (w_resp_done) w_state_next = c_ST_IDLE;
            default:                    w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_last_lsu  <= 1'b0;
            r_owner_lsu <= 1'b0;
            r_wen       <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wmask     <= 8'd0;
            r_resp_data <= 32'd0;
        end else begin
            if (w_accept) begin
                // IFU fetches are always reads: write controls are zeroed.
                r_owner_lsu <= w_grant_lsu;
                r_last_lsu  <= w_grant_lsu;
                r_addr      <= w_grant_lsu ? lsu_addr : ifu_addr;
                r_wen       <= w_grant_lsu && lsu_wen;
                r_wdata     <= w_grant_lsu ? lsu_wdata : 32'd0;
                r_wmask     <= w_grant_lsu ? lsu_wmask : 8'd0;
                r_cnt       <= c_CNT_INIT;
            end
            if (r_state == c_ST_WAIT) begin
                if (r_cnt == 4'd0) begin
                    r_resp_data <= r_wen ? 32'd0 : mem_rdata;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    assign ifu_req_ready  = w_grant_ifu;
    assign lsu_req_ready  = w_grant_lsu;

    assign ifu_resp_valid = w_in_resp && !r_owner_lsu;
    assign lsu_resp_valid = w_in_resp && r_owner_lsu;
    assign ifu_resp_data  = ifu_resp_valid ? r_resp_data : 32'd0;
    assign lsu_resp_data  = lsu_resp_valid ? r_resp_data : 32'd0;

    assign mem_valid      = w_mem_fire;
    assign mem_raddr      = w_mem_fire ? r_addr  : 32'd0;
    assign mem_waddr      = w_mem_fire ? r_addr  : 32'd0;
    assign mem_wen        = w_mem_fire && r_wen;
    assign mem_wdata      = w_mem_fire ? r_wdata : 32'd0;
    assign mem_wmask      = w_mem_fire ? r_wmask : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pmem_arbiter
//  Description : Directed self-checking bench, LATENCY=1 and LATENCY=3 DUTs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pmem_arbiter;

    logic        clk;
    logic        rst_n1;
    logic        rst_n3;
    logic        ifu_req_valid;
    logic [31:0] ifu_addr;
    logic        ifu_resp_ready;
    logic        lsu_req_valid;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_resp_ready;
    logic [31:0] mem_rdata;

    logic        ifu_req_ready_1, ifu_resp_valid_1, lsu_req_ready_1, lsu_resp_valid_1;
    logic [31:0] ifu_resp_data_1, lsu_resp_data_1;
    logic        mem_valid_1, mem_wen_1;
    logic [31:0] mem_raddr_1, mem_waddr_1, mem_wdata_1;
    logic [7:0]  mem_wmask_1;

    logic        ifu_req_ready_3, ifu_resp_valid_3, lsu_req_ready_3, lsu_resp_valid_3;
    logic [31:0] ifu_resp_data_3, lsu_resp_data_3;
    logic        mem_valid_3, mem_wen_3;
    logic [31:0] mem_raddr_3, mem_waddr_3, mem_wdata_3;
    logic [7:0]  mem_wmask_3;

    int total;
    int bad;

    pmem_arbiter #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n1),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready_1), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid_1), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_data(ifu_resp_data_1),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready_1), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid_1), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_data(lsu_resp_data_1),
        .mem_valid(mem_valid_1), .mem_raddr(mem_raddr_1), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen_1), .mem_waddr(mem_waddr_1), .mem_wdata(mem_wdata_1), .mem_wmask(mem_wmask_1)
    );

    pmem_arbiter #(.LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n3),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready_3), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid_3), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_data(ifu_resp_data_3),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready_3), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid_3), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_data(lsu_resp_data_3),
        .mem_valid(mem_valid_3), .mem_raddr(mem_raddr_3), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen_3), .mem_waddr(mem_waddr_3), .mem_wdata(mem_wdata_3), .mem_wmask(mem_wmask_3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One LATENCY=1 read with both requesters held valid.
    task automatic txn_l1(input logic exp_lsu);
        #1;
        chk1("rr_ifu_ready", ifu_req_ready_1, !exp_lsu);
        chk1("rr_lsu_ready", lsu_req_ready_1, exp_lsu);
        tick();
        chk1("rr_mem_valid", mem_valid_1, 1'b1);
        tick();
        chk1("rr_lsu_resp_valid", lsu_resp_valid_1, exp_lsu);
        chk1("rr_ifu_resp_valid", ifu_resp_valid_1, !exp_lsu);
        ifu_resp_ready = 1'b1;
        lsu_resp_ready = 1'b1;
        tick();
        ifu_resp_ready = 1'b0;
        lsu_resp_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        rst_n1 = 1'b0;
        rst_n3 = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_addr = 32'd0;
        ifu_resp_ready = 1'b0;
        lsu_req_valid = 1'b1;
        lsu_addr = 32'd0;
        lsu_wen = 1'b0;
        lsu_wdata = 32'd0;
        lsu_wmask = 8'd0;
        lsu_resp_ready = 1'b0;
        mem_rdata = 32'd0;

        // Outputs forced low in reset even with requests pending
        repeat (2) tick();
        chk1("rst_ifu_ready", ifu_req_ready_1, 1'b0);
        chk1("rst_lsu_ready", lsu_req_ready_1, 1'b0);
        chk1("rst_mem_valid", mem_valid_1, 1'b0);
        chk1("rst_ifu_resp_valid", ifu_resp_valid_1, 1'b0);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rst_n1 = 1'b1;
        tick();

        // LATENCY=1 IFU fetch
        ifu_req_valid = 1'b1;
        ifu_addr  = 32'h8000_0000;
        mem_rdata = 32'h0000_0413;
        #1;
        chk1("fetch_ifu_ready", ifu_req_ready_1, 1'b1);
        chk1("fetch_lsu_ready", lsu_req_ready_1, 1'b0);
        chk1("fetch_mem_idle", mem_valid_1, 1'b0);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk1("fetch_mem_valid", mem_valid_1, 1'b1);
        chk32("fetch_mem_raddr", mem_raddr_1, 32'h8000_0000);
        chk1("fetch_mem_wen", mem_wen_1, 1'b0);
        chk1("fetch_wait_ready", ifu_req_ready_1, 1'b0);
        tick();
        chk1("fetch_resp_valid", ifu_resp_valid_1, 1'b1);
        chk32("fetch_resp_data", ifu_resp_data_1, 32'h0000_0413);
        chk1("fetch_mem_after", mem_valid_1, 1'b0);
        ifu_resp_ready = 1'b1;
        tick();
        ifu_resp_ready = 1'b0;
        #1;
        chk1("fetch_resp_clear", ifu_resp_valid_1, 1'b0);
        chk32("fetch_resp_data_clear", ifu_resp_data_1, 32'd0);

        // Round-robin from fresh reset: LSU, IFU, LSU, IFU, LSU
        rst_n1 = 1'b0;
        tick();
        rst_n1 = 1'b1;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0010;
        lsu_addr = 32'h8000_0020;
        txn_l1(1'b1);
        txn_l1(1'b0);
        txn_l1(1'b1);
        txn_l1(1'b0);
        txn_l1(1'b1);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        tick();

        // LSU write
        lsu_req_valid = 1'b1;
        lsu_wen   = 1'b1;
        lsu_addr  = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF;
        lsu_wmask = 8'h0F;
        mem_rdata = 32'h1234_5678;
        #1;
        chk1("wr_lsu_ready", lsu_req_ready_1, 1'b1);
        tick();
        lsu_req_valid = 1'b0;
        lsu_wen = 1'b0;
        #1;
        chk1("wr_mem_valid", mem_valid_1, 1'b1);
        chk1("wr_mem_wen", mem_wen_1, 1'b1);
        chk32("wr_mem_waddr", mem_waddr_1, 32'h8000_1000);
        chk32("wr_mem_raddr", mem_raddr_1, 32'h8000_1000);
        chk32("wr_mem_wdata", mem_wdata_1, 32'hDEAD_BEEF);
        chk32("wr_mem_wmask", {24'd0, mem_wmask_1}, 32'h0000_000F);
        tick();
        chk1("wr_mem_once", mem_valid_1, 1'b0);
        chk32("wr_mem_wdata_idle", mem_wdata_1, 32'd0);
        chk1("wr_resp_valid", lsu_resp_valid_1, 1'b1);
        chk32("wr_resp_data", lsu_resp_data_1, 32'd0);
        lsu_resp_ready = 1'b1;
        tick();
        lsu_resp_ready = 1'b0;

        // LATENCY=3 with response back-pressure
        rst_n1 = 1'b0;
        rst_n3 = 1'b1;
        tick();
        lsu_req_valid = 1'b1;
        lsu_addr  = 32'h8000_0200;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        chk1("l3_lsu_ready", lsu_req_ready_3, 1'b1);
        tick();
        lsu_req_valid = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0300;
        #1;
        chk1("l3_ifu_ignored_wait", ifu_req_ready_3, 1'b0);
        chk1("l3_mem_t1", mem_valid_3, 1'b0);
        tick();
        chk1("l3_mem_t2", mem_valid_3, 1'b0);
        tick();
        chk1("l3_mem_t3", mem_valid_3, 1'b1);
        chk32("l3_mem_raddr", mem_raddr_3, 32'h8000_0200);
        tick();
        mem_rdata = 32'h1111_2222;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1("l3_hold_valid", lsu_resp_valid_3, 1'b1);
            chk32("l3_hold_data", lsu_resp_data_3, 32'hCAFE_F00D);
            chk1("l3_ifu_ignored_resp", ifu_req_ready_3, 1'b0);
            tick();
        end
        lsu_resp_ready = 1'b1;
        #1;
        chk1("l3_resp_last", lsu_resp_valid_3, 1'b1);
        tick();
        lsu_resp_ready = 1'b0;
        mem_rdata = 32'h0000_0013;
        #1;
        chk1("l3_idle_resp", lsu_resp_valid_3, 1'b0);
        chk1("l3_ifu_ready_idle", ifu_req_ready_3, 1'b1);
        tick();
        ifu_req_valid = 1'b0;
        tick();
        tick();
        chk1("l3_ifu_mem_valid", mem_valid_3, 1'b1);
        chk32("l3_ifu_mem_raddr", mem_raddr_3, 32'h8000_0300);
        tick();
        chk1("l3_ifu_resp_valid", ifu_resp_valid_3, 1'b1);
        chk32("l3_ifu_resp_data", ifu_resp_data_3, 32'h0000_0013);
        ifu_resp_ready = 1'b1;
        tick();
        ifu_resp_ready = 1'b0;
        #1;
        chk1("l3_ifu_resp_clear", ifu_resp_valid_3, 1'b0);

        // Reset mid-transaction discards it and restores pointer
        lsu_req_valid = 1'b1;
        lsu_addr = 32'h8000_0400;
        #1;
        chk1("abort_lsu_ready", lsu_req_ready_3, 1'b1);
        tick();
        lsu_req_valid = 1'b0;
        rst_n3 = 1'b0;
        #1;
        chk1("abort_rst_mem_valid", mem_valid_3, 1'b0);
        chk1("abort_rst_lsu_ready", lsu_req_ready_3, 1'b0);
        chk1("abort_rst_resp_valid", lsu_resp_valid_3, 1'b0);
        chk32("abort_rst_mem_raddr", mem_raddr_3, 32'd0);
        tick();
        rst_n3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("abort_no_mem_valid", mem_valid_3, 1'b0);
            chk1("abort_no_resp_valid", lsu_resp_valid_3, 1'b0);
            tick();
        end
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        chk1("abort_tie_lsu", lsu_req_ready_3, 1'b1);
        chk1("abort_tie_ifu", ifu_req_ready_3, 1'b0);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
